// File: rtl/user_input_ctrl.sv
// Confirm-button input capture for the CPU input instruction: synchronises SW/KEY,
// debounces KEY, and latches the switch value on a stable press while a request is open.
module user_input_ctrl #(
   parameter int SW_WIDTH        = 16,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                halt,
   input  logic                input_req,
   input  logic [SW_WIDTH-1:0] SW,
   input  logic                KEY,
   output logic [31:0]         data_out,
   output logic                data_valid,
   output logic                waiting,
   output logic [31:0]         live_value
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   logic                r_key_s1, r_key_s2;
   logic [SW_WIDTH-1:0] r_sw_s1, r_sw_s2;
   logic                r_key_stable, r_key_stable_d;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_press_evt;
   state_t              r_state, w_next;
   logic [31:0]         r_data_out;
   logic                r_data_valid, r_waiting;
   logic                w_capture;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_key_s1 <= 1'b1;
         r_key_s2 <= 1'b1;
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
      end else begin
         r_key_s1 <= KEY;
         r_key_s2 <= r_key_s1;
         r_sw_s1  <= SW;
         r_sw_s2  <= r_sw_s1;
      end
   end

   // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_key_stable   <= 1'b1;
         r_key_stable_d <= 1'b1;
         r_cnt          <= '0;
         r_press_evt    <= 1'b0;
      end else begin
         if (r_key_s2 == r_key_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_key_stable <= r_key_s2;
            r_cnt        <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_key_stable_d <= r_key_stable;
         r_press_evt    <= r_key_stable_d & ~r_key_stable;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (input_req && !halt) w_next = S_WAIT;
         S_WAIT: begin
            if (halt || !input_req) w_next = S_IDLE;
            else if (r_press_evt)   w_next = S_HOLD;
         end
         S_HOLD: if (halt || !input_req) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_capture = (r_state == S_WAIT) && !halt && input_req && r_press_evt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_waiting    <= 1'b0;
      end else begin
         if (w_capture) r_data_out <= 32'(r_sw_s2);
         r_data_valid <= w_capture;
         r_waiting    <= (w_next == S_WAIT);
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign waiting    = r_waiting;
   assign live_value = 32'(r_sw_s2);

endmodule
